rng_index_scheduler: RTL and testbench
======================================

# rng_index_scheduler

Shares the synchronized 64-bit LFSR output among `NUM_REQ` RANSAC hypothesis engines. On request, it draws `SAMPLES` distinct point indices in `[0, point_count)` by masked rejection sampling. Requesters are served round-robin, and each finished index set is returned on one shared, handshaked result bus. The block sits in the read-clock domain, directly downstream of the LFSR synchronizer.

## Interface
- `NUM_REQ`, 4: number of requesters (2..16).
- `INDEX_WIDTH`, 16: index width; `point_count` is at most 2^INDEX_WIDTH-1.
- `SAMPLES`, 3: indices per set (1..8).
- `MAX_TRIES`, 255: consecutive-rejection limit, used only with the timeout macro.

Ports:
- `read_clock`, in, 1: sole clock.
- `read_reset`, in, 1: asynchronous, active-high reset.
- `random_value`, in, 64: synchronized LFSR word.
- `point_count`, in, INDEX_WIDTH: number of valid points.
- `req_valid`, in, NUM_REQ: level request, one bit per requester.
- `sample_valid`, out, 1: result available.
- `sample_ready`, in, 1: consumer accepts the result.
- `sample_dest`, out, $clog2(NUM_REQ): index of the served requester.
- `sample_indices`, out, SAMPLES*INDEX_WIDTH: index k occupies bits [k*INDEX_WIDTH +: INDEX_WIDTH].
- `sample_error`, out, 1: set is invalid (degenerate count or timeout).
- `busy`, out, 1: high whenever the state is not IDLE.

## Operation
- FSM states: IDLE, DRAW, OFFER.
- **IDLE**
  - If any `req_valid` bit is set, grant the first set bit at or after `rr_ptr`, wrapping around.
  - Register `sample_dest`, latch `point_count` into `pc`, clear `k`, `tries` and all indices, then go to DRAW.
  - If `pc < SAMPLES`, go straight to OFFER instead, with `sample_error=1` and all indices 0.
- **DRAW** evaluates one candidate per cycle.
  - Candidate: `c = random_value[INDEX_WIDTH-1:0] & mask`. `mask` is all ones up to and including the MSB of `pc-1`; for `pc=1`, `mask=0`.
  - Reject when any of these holds: `c >= pc`; `c` equals an already accepted index `0..k-1`; `random_value` equals the word sampled in the previous DRAW cycle (a stale word).
  - On accept, store `c` at slot `k` and increment `k`. When `k` reaches `SAMPLES`, go to OFFER.
  - On reject, increment `tries`. `tries` resets to 0 on every accept.
- **OFFER**
  - `sample_valid=1`; `sample_dest`, `sample_indices` and `sample_error` are held stable.
  - On `sample_valid && sample_ready`: set `rr_ptr = sample_dest + 1` (mod NUM_REQ), deassert `sample_valid`, return to IDLE.
- Requests are never withdrawn from the block's point of view:
  - Once granted, a draw completes and its result is offered even if `req_valid[dest]` drops.
  - A requester holding `req_valid` after its transfer is a new request.
- Changes on `point_count` after the grant are ignored; `pc` is used.
- Width rules: comparisons are unsigned at INDEX_WIDTH. Only the low INDEX_WIDTH bits of `random_value` are used.

## Timing
- Reset values:
  - `sample_valid=0`, `sample_dest=0`, `sample_indices=0`, `sample_error=0`, `busy=0`.
  - `rr_ptr=0`, state IDLE, `k=0`, `tries=0`, previous-word register 0.
- Arbitration takes 1 cycle: a request seen in cycle N produces DRAW in cycle N+1.
- With no rejections, `sample_valid` rises in cycle N+1+SAMPLES. Each rejection adds 1 cycle.
- Degenerate count: `sample_valid` rises in cycle N+1.
- After the handshake in cycle M, the block is IDLE in M+1. The next grant is effective in M+2, so the earliest next `sample_valid` is M+2+SAMPLES.
- Simultaneous requests: exactly one grant per IDLE cycle, in round-robin order, so a requester waits at most NUM_REQ-1 sets.
- `read_reset` asserted mid-DRAW or mid-OFFER: the set is discarded and all outputs return to reset values immediately. No partial result is ever presented.

## Configuration
- Macro `RNG_SCHED_TIMEOUT_EN`.
- Defined: when `tries` reaches `MAX_TRIES` in DRAW, go to OFFER with `sample_error=1`. Indices accepted so far are kept and the remaining slots are 0.
- Undefined: no `tries` counter is built, `sample_error` is set only for degenerate counts, and DRAW runs until the set is complete.

## Test plan
- **Basic set.** Reset; `point_count=100`; `req_valid=4'b0001`; `random_value` steps 5, 17, 42 → `sample_valid` 4 cycles after the request, indices {5,17,42}, `dest=0`, `error=0`.
- **Rejection.** `point_count=10` (mask 15); feed 12, 3, 3, 9, 9, 0 → 12 rejected (≥pc), second 3 rejected (duplicate), second 9 rejected (stale word); indices {3,9,0}, latency 7 cycles.
- **Round-robin.** `req_valid=4'b1111` held, `sample_ready=1` → `sample_dest` sequence 0,1,2,3,0.
- **Degenerate count.** `point_count=2`, `SAMPLES=3` → `sample_valid` 1 cycle after grant, `error=1`, indices all 0.
- **Backpressure and reset.**
  - Hold `sample_ready=0` for 10 cycles → outputs stay stable.
  - Assert `read_reset` during OFFER → `sample_valid=0` asynchronously, `rr_ptr=0`.
- **Timeout** (macro defined, `MAX_TRIES=255`). `point_count=5`; hold `random_value=7` → `error=1` after 255 rejections; indices all 0.

Source files
------------

// File: rtl/rng_index_scheduler.sv
// rng_index_scheduler: round-robin sampler of distinct point indices from a shared LFSR word.
// Define RNG_SCHED_TIMEOUT_EN to abort a set after MAX_TRIES consecutive rejections.
module rng_index_scheduler #(
    parameter int NUM_REQ     = 4,
    parameter int INDEX_WIDTH = 16,
    parameter int SAMPLES     = 3,
    parameter int MAX_TRIES   = 255
) (
    input  logic                           read_clock,
    input  logic                           read_reset,
    input  logic [63:0]                    random_value,
    input  logic [INDEX_WIDTH-1:0]         point_count,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic                           sample_valid,
    input  logic                           sample_ready,
    output logic [$clog2(NUM_REQ)-1:0]     sample_dest,
    output logic [SAMPLES*INDEX_WIDTH-1:0] sample_indices,
    output logic                           sample_error,
    output logic                           busy
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int K_W   = $clog2(SAMPLES + 1);

    typedef enum logic [1:0] {
        IDLE,
        DRAW,
        OFFER
    } state_t;

    if (NUM_REQ < 2 || SAMPLES < 1 || MAX_TRIES < 1) begin : g_param_check
        $error("rng_index_scheduler: parameter out of range");
    end

    state_t state, state_next;

    logic [PTR_W-1:0]       rr_ptr;
    logic [PTR_W:0]         slot;
    logic [PTR_W-1:0]       grant_idx;
    logic                   grant_found;
    logic [INDEX_WIDTH-1:0] pc;
    logic [INDEX_WIDTH-1:0] mask;
    logic [INDEX_WIDTH-1:0] cand;
    logic [K_W-1:0]         k;
    logic [63:0]            prev_word;
    logic                   degenerate;
    logic                   dup;
    logic                   accept;
    logic                   last_slot;
    logic                   give_up;

    // First requester at or after rr_ptr, wrapping around.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        slot        = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            slot = {1'b0, rr_ptr} + (PTR_W+1)'(i);
            if (slot >= (PTR_W+1)'(NUM_REQ)) begin
                slot = slot - (PTR_W+1)'(NUM_REQ);
            end
            if (!grant_found && req_valid[slot[PTR_W-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = slot[PTR_W-1:0];
            end
        end
    end

    // Smear the MSB of pc-1 downward; pc=1 yields an all-zero mask.
    always_comb begin
        mask = pc - INDEX_WIDTH'(1);
        for (int i = 1; i < INDEX_WIDTH; i++) begin
            mask = mask | (mask >> i);
        end
    end

    assign cand       = random_value[INDEX_WIDTH-1:0] & mask;
    assign degenerate = point_count < INDEX_WIDTH'(SAMPLES);
    assign last_slot  = k == K_W'(SAMPLES - 1);

    always_comb begin
        dup = 1'b0;
        for (int s = 0; s < SAMPLES; s++) begin
            if (K_W'(s) < k && sample_indices[s*INDEX_WIDTH +: INDEX_WIDTH] == cand) begin
                dup = 1'b1;
            end
        end
    end

    assign accept = (cand < pc) && !dup && (random_value != prev_word);

`ifdef RNG_SCHED_TIMEOUT_EN
    localparam int T_W = $clog2(MAX_TRIES + 1);

    logic [T_W-1:0] tries;

    assign give_up = !accept && (tries == T_W'(MAX_TRIES - 1));

    always_ff @(posedge read_clock or posedge read_reset) begin
        if (read_reset) begin
            tries <= '0;
        end else if (state == IDLE || accept) begin
            tries <= '0;
        end else if (state == DRAW) begin
            tries <= tries + T_W'(1);
        end
    end
`else
    assign give_up = 1'b0;
`endif

    always_ff @(posedge read_clock or posedge read_reset) begin
        if (read_reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (grant_found) begin
                    state_next = degenerate ? OFFER : DRAW;
                end
            end
            DRAW: begin
                if ((accept && last_slot) || give_up) begin
                    state_next = OFFER;
                end
            end
            OFFER: begin
                if (sample_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge read_clock or posedge read_reset) begin
        if (read_reset) begin
            rr_ptr         <= '0;
            sample_dest    <= '0;
            sample_indices <= '0;
            sample_error   <= 1'b0;
            pc             <= '0;
            k              <= '0;
            prev_word      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_found) begin
                        sample_dest    <= grant_idx;
                        pc             <= point_count;
                        k              <= '0;
                        sample_indices <= '0;
                        sample_error   <= degenerate;
                    end
                end
                DRAW: begin
                    prev_word <= random_value;
                    if (accept) begin
                        sample_indices[int'(k)*INDEX_WIDTH +: INDEX_WIDTH] <= cand;
                        k <= k + K_W'(1);
                    end
                    if (give_up) begin
                        sample_error <= 1'b1;
                    end
                end
                OFFER: begin
                    if (sample_ready) begin
                        rr_ptr <= (sample_dest == PTR_W'(NUM_REQ - 1)) ?
                                  '0 : sample_dest + PTR_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign sample_valid = state == OFFER;
    assign busy         = state != IDLE;

endmodule

// File: tb/tb_rng_index_scheduler.sv
// tb_rng_index_scheduler: directed vector table, corner sequences and a
// randomized transaction-level reference model for rng_index_scheduler.
module tb_rng_index_scheduler;

    localparam int NR = 4;
    localparam int IW = 16;
    localparam int NS = 3;
    localparam int MT = 255;

    logic           read_clock = 1'b0;
    logic           read_reset;
    logic [63:0]    random_value;
    logic [IW-1:0]  point_count;
    logic [NR-1:0]  req_valid;
    logic           sample_valid;
    logic           sample_ready;
    logic [1:0]     sample_dest;
    logic [NS*IW-1:0] sample_indices;
    logic           sample_error;
    logic           busy;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] fresh_cnt = 32'd0;
    int          m_rr;
    logic [63:0] m_last;

    typedef struct {
        logic [15:0] pc;
        logic [3:0]  req;
        int          dest;
        logic [47:0] idx;
        logic        err;
        int          lat;
        int          hold;
        int          wbase;
        int          wcnt;
    } vec_t;

    vec_t        vecs[$];
    logic [63:0] wpool[$];

    rng_index_scheduler #(
        .NUM_REQ(NR),
        .INDEX_WIDTH(IW),
        .SAMPLES(NS),
        .MAX_TRIES(MT)
    ) dut (
        .read_clock(read_clock),
        .read_reset(read_reset),
        .random_value(random_value),
        .point_count(point_count),
        .req_valid(req_valid),
        .sample_valid(sample_valid),
        .sample_ready(sample_ready),
        .sample_dest(sample_dest),
        .sample_indices(sample_indices),
        .sample_error(sample_error),
        .busy(busy)
    );

    always #5 read_clock = ~read_clock;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge read_clock);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] fresh();
        fresh_cnt++;
        return {fresh_cnt, 32'($urandom)};
    endfunction

    function automatic int pow2_mask(input int pc);
        int m = 1;
        while (m < pc) m = m * 2;
        return m - 1;
    endfunction

    task automatic do_reset();
        read_reset   = 1'b1;
        req_valid    = '0;
        sample_ready = 1'b0;
        step();
        step();
        read_reset = 1'b0;
    endtask

    task automatic add_vec(input logic [15:0] pc, input logic [3:0] req, input int dest,
                           input logic [47:0] idx, input logic err, input int lat,
                           input int hold, input int nw,
                           input logic [63:0] w0, input logic [63:0] w1,
                           input logic [63:0] w2, input logic [63:0] w3,
                           input logic [63:0] w4, input logic [63:0] w5);
        vec_t        v;
        logic [63:0] ws[6];
        ws = '{w0, w1, w2, w3, w4, w5};
        v.pc    = pc;
        v.req   = req;
        v.dest  = dest;
        v.idx   = idx;
        v.err   = err;
        v.lat   = lat;
        v.hold  = hold;
        v.wbase = wpool.size();
        v.wcnt  = nw;
        for (int i = 0; i < nw; i++) wpool.push_back(ws[i]);
        vecs.push_back(v);
    endtask

    task automatic run_directed(input int n);
        vec_t v;
        int   lat;
        int   wi;
        v = vecs[n];
        req_valid    = v.req;
        point_count  = v.pc;
        random_value = 64'hABCD_0000_0000_0000 | 64'(n);
        step();
        check("busy_grant", 64'(busy), 64'd1);
        req_valid   = '0;
        point_count = '0;
        lat = 1;
        wi  = 0;
        while (!sample_valid && lat < 400) begin
            if (wi < v.wcnt) begin
                random_value = wpool[v.wbase + wi];
                wi++;
            end
            step();
            lat++;
        end
        check("vec_latency", 64'(lat), 64'(v.lat));
        check("vec_dest", 64'(sample_dest), 64'(v.dest));
        check("vec_indices", 64'(sample_indices), 64'(v.idx));
        check("vec_error", 64'(sample_error), 64'(v.err));
        sample_ready = 1'b0;
        for (int h = 0; h < v.hold; h++) begin
            step();
            check("vec_hold", {sample_valid, sample_dest, sample_indices, sample_error},
                  {1'b1, 2'(v.dest), v.idx, v.err});
        end
        sample_ready = 1'b1;
        step();
        sample_ready = 1'b0;
        check("vec_release", {sample_valid, busy}, 2'b00);
    endtask

    task automatic rr_test();
        int          seen[$];
        int          at[$];
        int          cyc = 0;
        logic [31:0] wc  = 0;
        do_reset();
        req_valid    = 4'hF;
        sample_ready = 1'b1;
        point_count  = 16'd100;
        while (seen.size() < 5 && cyc < 100) begin
            wc++;
            random_value = {wc, 16'h0, 16'(wc % 100)};
            step();
            cyc++;
            if (sample_valid) begin
                seen.push_back(int'(sample_dest));
                at.push_back(cyc);
                if (seen.size() == 5) req_valid = '0;
            end
        end
        step();
        sample_ready = 1'b0;
        check("rr_count", 64'(seen.size()), 64'd5);
        foreach (seen[i]) begin
            check("rr_dest", 64'(seen[i]), 64'(i % NR));
            check("rr_cycle", 64'(at[i]), 64'(4 + 5 * i));
        end
    endtask

    task automatic reset_test();
        int lat;
        req_valid    = 4'b0010;
        point_count  = 16'd50;
        sample_ready = 1'b0;
        random_value = fresh();
        step();
        req_valid = '0;
        lat = 1;
        while (!sample_valid && lat < 200) begin
            random_value = fresh();
            step();
            lat++;
        end
        check("rst_pre_valid", 64'(sample_valid), 64'd1);
        check("rst_pre_dest", 64'(sample_dest), 64'd1);
        #3 read_reset = 1'b1;
        #1;
        check("rst_async", {sample_valid, busy, sample_dest, sample_indices, sample_error}, 64'd0);
        step();
        read_reset   = 1'b0;
        req_valid    = 4'hF;
        random_value = fresh();
        step();
        req_valid = '0;
        lat = 1;
        while (!sample_valid && lat < 200) begin
            random_value = fresh();
            step();
            lat++;
        end
        check("rst_rr_valid", 64'(sample_valid), 64'd1);
        check("rst_rr_dest", 64'(sample_dest), 64'd0);
        sample_ready = 1'b1;
        step();
        sample_ready = 1'b0;
    endtask

    task automatic run_random();
        logic [3:0]  req;
        int          pc;
        int          dest;
        int          lat;
        int          tries;
        int          c;
        int          mask;
        int          hold;
        bit          timed_out;
        bit          ok;
        bit          first;
        int          acc[$];
        logic [63:0] w;
        logic [63:0] prev_w;
        logic [47:0] exp_idx;
        req = 4'($urandom_range(1, 15));
        case ($urandom_range(0, 9))
            0:       pc = $urandom_range(0, 2);
            1:       pc = 65535 - $urandom_range(0, 3);
            default: pc = $urandom_range(3, 40);
        endcase
        dest = -1;
        for (int i = 0; i < NR; i++) begin
            if (dest < 0 && req[(m_rr + i) % NR]) dest = (m_rr + i) % NR;
        end
        req_valid    = req;
        point_count  = 16'(pc);
        w            = fresh();
        random_value = w;
        step();
        req_valid   = 4'($urandom);
        point_count = 16'($urandom);
        timed_out = 0;
        tries     = 0;
        lat       = 1;
        first     = 1;
        if (pc >= NS) begin
            mask = pow2_mask(pc);
            while (acc.size() < NS && !timed_out && lat < 600) begin
                check("rand_drawing", {sample_valid, busy}, 2'b01);
                prev_w = w;
                w = (!first && $urandom_range(0, 5) == 0) ? prev_w : fresh();
                first = 0;
                c  = int'(w[15:0]) & mask;
                ok = (c < pc) && (w != m_last);
                foreach (acc[i]) if (acc[i] == c) ok = 0;
                m_last = w;
                if (ok) begin
                    acc.push_back(c);
                    tries = 0;
                end else begin
                    tries++;
                end
`ifdef RNG_SCHED_TIMEOUT_EN
                if (tries == MT) timed_out = 1;
`endif
                random_value = w;
                step();
                lat++;
            end
        end
        exp_idx = '0;
        foreach (acc[i]) exp_idx[i*IW +: IW] = 16'(acc[i]);
        check("rand_valid", 64'(sample_valid), 64'd1);
        check("rand_dest", 64'(sample_dest), 64'(dest));
        check("rand_indices", 64'(sample_indices), 64'(exp_idx));
        check("rand_error", 64'(sample_error), 64'((pc < NS) || timed_out));
        hold = $urandom_range(0, 3);
        for (int h = 0; h < hold; h++) begin
            random_value = fresh();
            step();
            check("rand_hold", {sample_valid, sample_dest, sample_indices, sample_error},
                  {1'b1, 2'(dest), exp_idx, 1'((pc < NS) || timed_out)});
        end
        sample_ready = 1'b1;
        random_value = fresh();
        step();
        sample_ready = 1'b0;
        check("rand_release", {sample_valid, busy}, 2'b00);
        m_rr = (dest + 1) % NR;
    endtask

    initial begin
        read_reset   = 1'b1;
        random_value = '0;
        point_count  = '0;
        req_valid    = '0;
        sample_ready = 1'b0;
        #1;
        check("reset_out", {sample_valid, busy, sample_dest, sample_indices, sample_error}, 64'd0);
        step();
        step();
        read_reset = 1'b0;

        add_vec(16'd100, 4'b0001, 0, {16'd42, 16'd17, 16'd5}, 1'b0, 4, 10, 3,
                64'd5, 64'd17, 64'd42, 64'd0, 64'd0, 64'd0);
        add_vec(16'd10, 4'b0001, 0, {16'd0, 16'd9, 16'd3}, 1'b0, 7, 0, 6,
                64'd12, 64'd3, 64'd3, 64'd9, 64'd9, 64'd0);
        add_vec(16'd2, 4'b0100, 2, 48'd0, 1'b1, 1, 2, 0,
                64'd0, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0);
        add_vec(16'd0, 4'b0011, 0, 48'd0, 1'b1, 1, 0, 0,
                64'd0, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0);
        add_vec(16'd4, 4'b1010, 1, {16'd1, 16'd3, 16'd2}, 1'b0, 5, 1, 4,
                64'h1_0002, 64'h2_0002, 64'h3, 64'h5, 64'd0, 64'd0);
        add_vec(16'hFFFF, 4'b1111, 2, {16'h1234, 16'h0, 16'hFFFE}, 1'b0, 5, 0, 4,
                64'hFFFF, 64'hFFFE, 64'h0, 64'h1234, 64'd0, 64'd0);
        add_vec(16'd3, 4'b0001, 0, {16'd0, 16'd1, 16'd2}, 1'b0, 7, 0, 6,
                64'd3, 64'd2, 64'd1, 64'd1, 64'd2, 64'd0);
`ifdef RNG_SCHED_TIMEOUT_EN
        add_vec(16'd5, 4'b0010, 1, 48'd0, 1'b1, 1 + MT, 0, 1,
                64'd7, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0);
`endif
        for (int n = 0; n < vecs.size(); n++) run_directed(n);

        rr_test();
        reset_test();

        do_reset();
        m_rr   = 0;
        m_last = '0;
        repeat (150) run_random();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
